// File: rtl/intt_gs_butterfly.sv
// Inverse-NTT Gentleman-Sande butterfly modulo p = 2^33 - 2^20 + 1.
// Five-stage pipeline with a single global stall derived from the output handshake.
module intt_gs_butterfly (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [32:0] xin,
    input  logic [32:0] yin,
    input  logic [32:0] win,
    input  logic        half,
    output logic        in_ready,
    input  logic        out_ready,
    output logic [32:0] xout,
    output logic [32:0] yout,
    output logic        valid
);
    localparam int         W   = 33;
    localparam logic [W-1:0] P   = 33'h1_FFF0_0001;
    localparam logic [W:0]   P_X = {1'b0, P};

    // Multiply by 2^-1 mod p: odd residues become even once p is added.
    function automatic logic [W-1:0] halve(input logic [W-1:0] a);
        return a[0] ? W'(({1'b0, a} + P_X) >> 1) : (a >> 1);
    endfunction

    logic stall;

    logic           v1_q, h1_q;
    logic [W-1:0]   s1_q, s1_d, d1_q, d1_d, w1_q;
    logic [W:0]     sum_c;

    logic           v2_q, h2_q;
    logic [2*W-1:0] z2_q, z2_d;
    logic [W-1:0]   s2_q;

    logic           v3_q, h3_q;
    logic [53:0]    t3_q, t3_d;
    logic [W-1:0]   s3_q;

    logic           v4_q, h4_q;
    logic [41:0]    u4_c;
    logic [W:0]     f4_q, f4_d;
    logic [W-1:0]   s4_q;

    logic [W-1:0]   r5_c;
    logic [W-1:0]   xout_q, xout_d, yout_q, yout_d;
    logic           valid_q;

    assign stall    = valid_q && !out_ready;
    assign in_ready = !stall;
    assign xout     = xout_q;
    assign yout     = yout_q;
    assign valid    = valid_q;

    // S1: modular sum and difference, each needing at most one correction.
    assign sum_c = {1'b0, xin} + {1'b0, yin};
    assign s1_d  = (sum_c >= P_X) ? W'(sum_c - P_X) : W'(sum_c);
    assign d1_d  = (xin < yin) ? W'({1'b0, xin} + P_X - {1'b0, yin}) : (xin - yin);

    assign z2_d = (2*W)'(d1_q) * (2*W)'(w1_q);

    // Folds use 2^33 == 2^20 - 1 (mod p); each shrinks the operand without going negative.
    assign t3_d = 54'(z2_q[W-1:0]) + 54'({z2_q[2*W-1:W], 20'd0}) - 54'(z2_q[2*W-1:W]);
    assign u4_c = 42'(t3_q[W-1:0]) + 42'({t3_q[53:W], 20'd0}) - 42'(t3_q[53:W]);
    assign f4_d = 34'(u4_c[W-1:0]) + 34'({u4_c[41:W], 20'd0}) - 34'(u4_c[41:W]);

    assign r5_c = (f4_q >= P_X) ? W'(f4_q - P_X) : W'(f4_q);

    always_comb begin
        // NOTE: defaults first, then overrides, so no path through the block can infer a latch.
        xout_d = s4_q;
        yout_d = r5_c;
        if (h4_q) begin
            xout_d = halve(s4_q);
            yout_d = halve(r5_c);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: data registers are reset too; it keeps outputs at 0 and costs little at this depth.
            v1_q    <= 1'b0;
            h1_q    <= 1'b0;
            s1_q    <= '0;
            d1_q    <= '0;
            w1_q    <= '0;
            v2_q    <= 1'b0;
            h2_q    <= 1'b0;
            z2_q    <= '0;
            s2_q    <= '0;
            v3_q    <= 1'b0;
            h3_q    <= 1'b0;
            t3_q    <= '0;
            s3_q    <= '0;
            v4_q    <= 1'b0;
            h4_q    <= 1'b0;
            f4_q    <= '0;
            s4_q    <= '0;
            xout_q  <= '0;
            yout_q  <= '0;
            valid_q <= 1'b0;
        end else if (!stall) begin
            v1_q    <= en;
            h1_q    <= half;
            s1_q    <= s1_d;
            d1_q    <= d1_d;
            w1_q    <= win;
            v2_q    <= v1_q;
            h2_q    <= h1_q;
            z2_q    <= z2_d;
            s2_q    <= s1_q;
            v3_q    <= v2_q;
            h3_q    <= h2_q;
            t3_q    <= t3_d;
            s3_q    <= s2_q;
            v4_q    <= v3_q;
            h4_q    <= h3_q;
            f4_q    <= f4_d;
            s4_q    <= s3_q;
            xout_q  <= xout_d;
            yout_q  <= yout_d;
            valid_q <= v4_q;
        end
    end
endmodule

// File: tb/tb_intt_gs_butterfly.sv
// Directed and golden-model checks for the inverse-NTT butterfly pipeline,
// including latency, backpressure, bubble and asynchronous-reset sequences.
module tb_intt_gs_butterfly;
    localparam logic [32:0]  P    = 33'd8588886017;
    localparam logic [127:0] P128 = 128'd8588886017;
    localparam logic [127:0] INV2 = 128'd4294443009;

    typedef struct {
        logic [32:0] x, y, w;
        logic        h;
        logic [32:0] ex, ey;
    } vec_t;

    typedef struct {
        logic [32:0] ex, ey;
    } exp_t;

    logic        clk, reset, en, half, in_ready, out_ready, valid;
    logic [32:0] xin, yin, win, xout, yout;

    int   n_checks = 0;
    int   n_err    = 0;
    int   rx_count = 0;
    exp_t exp_q[$];

    intt_gs_butterfly dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .xin      (xin),
        .yin      (yin),
        .win      (win),
        .half     (half),
        .in_ready (in_ready),
        .out_ready(out_ready),
        .xout     (xout),
        .yout     (yout),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [32:0] x, input logic [32:0] y, input logic [32:0] w,
                                input logic h, input logic [32:0] ex, input logic [32:0] ey);
        vec_t v;
        v.x = x; v.y = y; v.w = w; v.h = h; v.ex = ex; v.ey = ey;
        return v;
    endfunction

    // Golden model: plain wide-integer modular arithmetic.
    function automatic vec_t gold(input logic [32:0] x, input logic [32:0] y,
                                  input logic [32:0] w, input logic h);
        logic [127:0] s, d, r;
        s = (128'(x) + 128'(y)) % P128;
        d = (128'(x) + P128 - 128'(y)) % P128;
        r = (d * 128'(w)) % P128;
        if (h) begin
            s = (s * INV2) % P128;
            r = (r * INV2) % P128;
        end
        return mk(x, y, w, h, 33'(s), 33'(r));
    endfunction

    function automatic logic [32:0] rnd33();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return 33'(r % 64'(P));
    endfunction

    // Scoreboard: every output transfer must match the oldest accepted input.
    always @(negedge clk) begin
        exp_t e;
        if (reset && valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_output: got x=%0d y=%0d, expected no output", xout, yout);
            end else begin
                e = exp_q.pop_front();
                rx_count++;
                check("out_x", 64'(xout), 64'(e.ex));
                check("out_y", 64'(yout), 64'(e.ey));
            end
        end
    end

    task automatic send(input vec_t v);
        int   guard;
        logic acc;
        exp_t e;
        guard = 0;
        xin = v.x; yin = v.y; win = v.w; half = v.h; en = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 40);
        if (!acc) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", guard);
        end else begin
            e.ex = v.ex;
            e.ey = v.ey;
            exp_q.push_back(e);
        end
        en = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Pipeline must be empty on entry; valid may rise only after the fifth edge.
    task automatic latency_probe(input vec_t v, input string tag);
        send(v);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, "_early_valid"}, 64'(valid), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        check({tag, "_valid"}, 64'(valid), 64'd1);
    endtask

    vec_t tbl[10];
    vec_t bp[20];

    initial begin
        int rx0;

        tbl[0] = mk(33'd5, 33'd3, 33'd2, 1'b0, 33'd8, 33'd4);
        tbl[1] = mk(33'd3, 33'd5, 33'd1, 1'b0, 33'd8, 33'd8588886015);
        tbl[2] = mk(33'd8588886016, 33'd8588886016, 33'd7, 1'b0, 33'd8588886015, 33'd0);
        tbl[3] = mk(33'd0, 33'd1, 33'd8588886016, 1'b0, 33'd1, 33'd1);
        tbl[4] = mk(33'd1, 33'd0, 33'd8588886016, 1'b0, 33'd1, 33'd8588886016);
        tbl[5] = mk(33'd1, 33'd0, 33'd1, 1'b1, 33'd4294443009, 33'd4294443009);
        tbl[6] = mk(33'd4, 33'd2, 33'd3, 1'b1, 33'd3, 33'd3);
        tbl[7] = mk(33'd8588886016, 33'd0, 33'd8588886016, 1'b0, 33'd8588886016, 33'd1);
        tbl[8] = mk(33'd0, 33'd8588886016, 33'd8588886016, 1'b0, 33'd8588886016, 33'd8588886016);
        tbl[9] = mk(33'd4294967296, 33'd0, 33'd4294967296, 1'b0, 33'd4294967296, 33'd6474694625);

        reset = 1'b0; en = 1'b0; half = 1'b0; out_ready = 1'b1;
        xin = '0; yin = '0; win = '0;
        #3;
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_xout", 64'(xout), 64'd0);
        check("reset_yout", 64'(yout), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        latency_probe(tbl[0], "basic");
        drain();

        for (int i = 0; i < 10; i++) send(tbl[i]);
        drain();

        for (int i = 0; i < 64; i++) send(gold(rnd33(), rnd33(), rnd33(), 1'($urandom_range(0, 1))));
        drain();

        for (int i = 0; i < 20; i++) bp[i] = gold(rnd33(), rnd33(), rnd33(), 1'(i % 3 == 0));
        rx0 = rx_count;
        fork
            begin
                for (int i = 0; i < 20; i++) send(bp[i]);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int c = 0; c < 7; c++) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_valid", 64'(valid), 64'd1);
                    check("stall_hold_x", 64'(xout), 64'(exp_q[0].ex));
                    check("stall_hold_y", 64'(yout), 64'(exp_q[0].ey));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("release_in_ready", 64'(in_ready), 64'd1);
            end
        join
        drain();
        check("bp_count", 64'(rx_count - rx0), 64'd20);

        out_ready = 1'b0;
        @(negedge clk);
        check("bubble_no_stall", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(tbl[5]);
        repeat (6) @(posedge clk);
        #1;
        check("late_stall_valid", 64'(valid), 64'd1);
        check("late_stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        drain();

        for (int i = 0; i < 5; i++) send(tbl[i + 2]);
        check("pre_reset_valid", 64'(valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_valid", 64'(valid), 64'd0);
        check("async_reset_xout", 64'(xout), 64'd0);
        check("async_reset_yout", 64'(yout), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        latency_probe(tbl[6], "post_reset");
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
